if_fetch_unit: RTL

//   Instruction-fetch stage directly upstream of the IF/ID pipeline register.

---
 rtl/if_fetch_unit.sv | 120 ++++++++++++
 1 files changed

// File: rtl/if_fetch_unit.sv
// Instruction-fetch stage: owns the PC, drives a one-outstanding variable-latency
// instruction-memory port and holds one fetched instruction for the IF/ID register.
module if_fetch_unit #(
    parameter logic [31:0] RESET_PC  = 32'h0000_0000,
    parameter logic [31:0] NOP_INSTR = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        stall,
    input  logic        redirect,
    input  logic [31:0] redirect_pc,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic        imem_ready,
    input  logic        imem_rvalid,
    input  logic [31:0] imem_rdata,
    output logic [31:0] IRout,
    output logic [31:0] PC_add_4out,
    output logic [31:0] PCout,
    output logic        fetch_valid,
    output logic        fsm_state
);

    // Memory handshake: a request transfers on any edge where imem_req & imem_ready;
    // its single response arrives on a later edge with imem_rvalid, at most one in flight.
    typedef enum logic {
        S_REQ  = 1'b0,
        S_WAIT = 1'b1
    } state_t;

    state_t      state, state_nxt;
    logic [31:0] pc, pc_nxt;
    logic        squash, squash_nxt;
    logic        fv_nxt;
    logic [31:0] ir_nxt, pco_nxt, pca4_nxt;
    logic        fire;
    logic        capture;
    logic [31:0] target;
    logic [31:0] pc_inc;

    assign target    = {redirect_pc[31:2], 2'b00};
    assign pc_inc    = pc + 32'd4;
    assign imem_addr = pc;
    // A new request may only go out when the buffer is empty or drains on this edge.
    assign imem_req  = (state == S_REQ) & (~fetch_valid | ~stall) & reset;
    assign fire      = imem_req & imem_ready;
    assign fsm_state = (state == S_WAIT);

    always_comb begin
        state_nxt  = state;
        pc_nxt     = pc;
        squash_nxt = squash;
        capture    = 1'b0;
        case (state)
            S_REQ: begin
                if (redirect) pc_nxt = target;
                if (fire) begin
                    state_nxt = S_WAIT;
                    if (redirect) squash_nxt = 1'b1;
                end
            end
            S_WAIT: begin
                if (imem_rvalid) begin
                    state_nxt  = S_REQ;
                    squash_nxt = 1'b0;
                    if (redirect) begin
                        pc_nxt = target;
                    end else if (!squash) begin
                        capture = 1'b1;
                        pc_nxt  = pc_inc;
                    end
                end else if (redirect) begin
                    // The in-flight word now belongs to the wrong path; drop it on arrival.
                    pc_nxt     = target;
                    squash_nxt = 1'b1;
                end
            end
        endcase
    end

    always_comb begin
        fv_nxt   = fetch_valid;
        ir_nxt   = IRout;
        pco_nxt  = PCout;
        pca4_nxt = PC_add_4out;
        if (redirect) begin
            fv_nxt = 1'b0;
            ir_nxt = NOP_INSTR;
        end else if (capture) begin
            fv_nxt   = 1'b1;
            ir_nxt   = imem_rdata;
            pco_nxt  = pc;
            pca4_nxt = pc_inc;
        end else if (fetch_valid && !stall) begin
            fv_nxt = 1'b0;
            ir_nxt = NOP_INSTR;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state       <= S_REQ;
            pc          <= RESET_PC;
            squash      <= 1'b0;
            fetch_valid <= 1'b0;
            IRout       <= NOP_INSTR;
            PCout       <= 32'd0;
            PC_add_4out <= 32'd0;
        end else begin
            state       <= state_nxt;
            pc          <= pc_nxt;
            squash      <= squash_nxt;
            fetch_valid <= fv_nxt;
            IRout       <= ir_nxt;
            PCout       <= pco_nxt;
            PC_add_4out <= pca4_nxt;
        end
    end

endmodule
